// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default build parameters and the address legality helper.
package dmem_responder_pkg;

  // Default word-address width of the backing store (1024 words).
  localparam int DEF_ADDR_WIDTH = 10;

  // Default number of wait states inserted before each access completes.
  localparam int DEF_WAIT_CYCLES = 2;

  // Width of the wait-state counter; wait states range over 0..15.
  localparam int CNT_WIDTH = 4;

  // Responder FSM states with fixed encodings.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when a byte address is misaligned or lies above the backing store.
  function automatic logic addrIllegal(input logic [31:0] addr, input int addrWidth);
    logic [31:0] high;
    high = addr >> (addrWidth + 2);
    return (addr[1:0] != 2'b00) || (high != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Backing store for the responder: single-port synchronous RAM with a write
// enable and a registered read port. The read register doubles as the
// core-facing read-data register, so it only updates on a read and is
// cleared by reset while the storage itself is never cleared.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  // Write port: commit the word on an enabled edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read port: load the addressed word on a read, otherwise hold the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read or write from the core while idle,
// stalls the core for a programmable number of wait states, performs the
// access and answers with a one-cycle acknowledge (plus error when the
// request was malformed). Malformed requests skip the wait states entirely
// and never touch the array or the read-data register.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [ADDR_WIDTH-1:0] r_wordAddr;
  logic [31:0]           r_data;
  logic                  r_write;
  logic                  r_ack;
  logic                  r_err;

  logic                  w_req;
  logic                  w_start;
  logic                  w_reqErr;
  logic                  w_lastWait;
  logic                  w_memWe;
  logic                  w_memRe;
  logic [ADDR_WIDTH-1:0] w_memAddr;
  logic [31:0]           w_memData;

  assign w_req      = mem_ren | mem_wen;
  assign w_start    = (r_state == IDLE) && w_req;
  assign w_reqErr   = addrIllegal(mem_addr, ADDR_WIDTH) || (mem_ren && mem_wen);
  assign w_lastWait = (r_state == WAIT) && (r_count == WAIT_LAST);

  // Next-state logic: errors and zero-wait builds jump straight to RESP.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_reqErr || (WAIT_CYCLES == 0)) begin
            w_nextState = RESP;
          end else begin
            w_nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_count == WAIT_LAST) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Array access steering: live inputs on a zero-wait accept, captured request at the end of WAIT; reset blocks any commit.
  always_comb begin
    w_memWe   = 1'b0;
    w_memRe   = 1'b0;
    w_memAddr = r_wordAddr;
    w_memData = r_data;
    if (w_lastWait) begin
      w_memWe = r_write;
      w_memRe = !r_write;
    end else if ((WAIT_CYCLES == 0) && w_start && !w_reqErr) begin
      w_memAddr = mem_addr[ADDR_WIDTH+1:2];
      w_memData = mem_din;
      w_memWe   = mem_wen;
      w_memRe   = mem_ren;
    end
    if (rst) begin
      w_memWe = 1'b0;
      w_memRe = 1'b0;
    end
  end

  // State register, wait counter and the one-cycle ack/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ack   <= (w_nextState == RESP);
      r_err   <= w_start && w_reqErr;
      if (w_start && !w_reqErr) begin
        r_count <= WAIT_LOAD;
      end else if (r_state == WAIT) begin
        r_count <= r_count - WAIT_LAST;
      end
    end
  end

  // Request capture: address, data and operation are latched only when accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!rst && w_start) begin
      r_wordAddr <= mem_addr[ADDR_WIDTH+1:2];
      r_data     <= mem_din;
      r_write    <= mem_wen;
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (w_memWe),
    .re   (w_memRe),
    .addr (w_memAddr),
    .wdata(w_memData),
    .rdata(mem_dout)
  );

  assign mem_stall = ((r_state == IDLE) && w_req) || (r_state == WAIT);
  assign mem_ack   = r_ack;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a two-wait-state instance and a zero-wait
// instance share clock and reset. Expected values come from a word-level
// memory model and the latency/error rules of the responder.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ren2, wen2, ren0, wen0;
  logic [31:0] addr2, din2, addr0, din0;
  logic [31:0] dout2, dout0;
  logic        stall2, ack2, err2, stall0, ack0, err0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_ren(ren2), .mem_wen(wen2), .mem_addr(addr2),
    .mem_din(din2), .mem_dout(dout2), .mem_stall(stall2), .mem_ack(ack2), .mem_err(err2)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_ren(ren0), .mem_wen(wen0), .mem_addr(addr0),
    .mem_din(din0), .mem_dout(dout0), .mem_stall(stall0), .mem_ack(ack0), .mem_err(err0)
  );

  int checkCount = 0;
  int passCount  = 0;
  int cyc = 0;
  logic [31:0] mdl2 [int];
  logic [31:0] mdl0 [int];
  logic [31:0] lastDout2 = 32'd0;

  // Free-running cycle counter used to time acknowledges.
  always @(posedge clk) cyc++;

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit isErr(input logic ren, input logic wen, input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 12) != 32'd0) || (ren && wen);
  endfunction

  task automatic runReq2(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nStall, output logic stallAtAck, output logic err,
                         output logic [31:0] dout, output logic [31:0] doutNext, output logic stallNext);
    lat = -1; nStall = 0; stallAtAck = 1'bx; err = 1'bx; dout = 'x;
    @(posedge clk); #1;
    ren2 = ren; wen2 = wen; addr2 = a; din2 = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack2 === 1'b1) begin
        lat = c; stallAtAck = stall2; err = err2; dout = dout2;
        break;
      end
      if (stall2 === 1'b1) nStall++;
    end
    @(posedge clk); #1;
    ren2 = 1'b0; wen2 = 1'b0;
    @(negedge clk);
    doutNext = dout2; stallNext = stall2;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    ren2 = 1'b0; wen2 = 1'b1; addr2 = 32'h40; din2 = 32'hCAFE0040;
    ren0 = 1'b0; wen0 = 1'b0; addr0 = 32'h0; din0 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkCount++; if (ack2 !== 1'b0) $display("[TB] FAIL rst_ack: got %b expected 0", ack2); else passCount++;
      checkCount++; if (err2 !== 1'b0) $display("[TB] FAIL rst_err: got %b expected 0", err2); else passCount++;
      checkCount++; if (dout2 !== 32'd0) $display("[TB] FAIL rst_dout: got %h expected 0", dout2); else passCount++;
      checkCount++; if (stall2 !== 1'b1) $display("[TB] FAIL rst_stall_req: got %b expected 1", stall2); else passCount++;
    end
    checkCount++; if (stall0 !== 1'b0) $display("[TB] FAIL rst_stall_idle: got %b expected 0", stall0); else passCount++;
    checkCount++; if (dout0 !== 32'd0) $display("[TB] FAIL rst_dout0: got %h expected 0", dout0); else passCount++;
    @(posedge clk); #1;
    rst = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack2 === 1'b1) begin lat = c; break; end
    end
    checkCount++; if (lat !== 3) $display("[TB] FAIL post_rst_latency: got %0d expected 3", lat); else passCount++;
    checkCount++; if (err2 !== 1'b0) $display("[TB] FAIL post_rst_err: got %b expected 0", err2); else passCount++;
    @(posedge clk); #1;
    wen2 = 1'b0;
    mdl2[int'(addr2[11:2])] = 32'hCAFE0040;
  endtask

  task automatic test_write_read();
    int lat, nStall; logic sa, e, sn; logic [31:0] d, dn;
    runReq2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, nStall, sa, e, d, dn, sn);
    mdl2[4] = 32'hDEADBEEF;
    checkCount++; if (lat !== 3) $display("[TB] FAIL wr_latency: got %0d expected 3", lat); else passCount++;
    checkCount++; if (nStall !== 3) $display("[TB] FAIL wr_stall_cycles: got %0d expected 3", nStall); else passCount++;
    checkCount++; if (sa !== 1'b0) $display("[TB] FAIL wr_stall_at_ack: got %b expected 0", sa); else passCount++;
    checkCount++; if (e !== 1'b0) $display("[TB] FAIL wr_err: got %b expected 0", e); else passCount++;
    checkCount++; if (d !== lastDout2) $display("[TB] FAIL wr_dout_hold: got %h expected %h", d, lastDout2); else passCount++;
    runReq2(1'b1, 1'b0, 32'h10, 32'h0, lat, nStall, sa, e, d, dn, sn);
    checkCount++; if (lat !== 3) $display("[TB] FAIL rd_latency: got %0d expected 3", lat); else passCount++;
    checkCount++; if (d !== 32'hDEADBEEF) $display("[TB] FAIL rd_data: got %h expected deadbeef", d); else passCount++;
    checkCount++; if (e !== 1'b0) $display("[TB] FAIL rd_err: got %b expected 0", e); else passCount++;
    checkCount++; if (dn !== 32'hDEADBEEF) $display("[TB] FAIL rd_data_next: got %h expected deadbeef", dn); else passCount++;
    lastDout2 = 32'hDEADBEEF;
  endtask

  task automatic test_errors();
    int lat, nStall; logic sa, e, sn; logic [31:0] d, dn;
    logic [31:0] bad [2];
    bad[0] = 32'h12; bad[1] = 32'h1000;
    for (int i = 0; i < 2; i++) begin
      runReq2(1'b1, 1'b0, bad[i], 32'h0, lat, nStall, sa, e, d, dn, sn);
      checkCount++; if (lat !== 1) $display("[TB] FAIL err%0d_latency: got %0d expected 1", i, lat); else passCount++;
      checkCount++; if (e !== 1'b1) $display("[TB] FAIL err%0d_flag: got %b expected 1", i, e); else passCount++;
      checkCount++; if (d !== lastDout2) $display("[TB] FAIL err%0d_dout: got %h expected %h", i, d, lastDout2); else passCount++;
      checkCount++; if (nStall !== 1) $display("[TB] FAIL err%0d_stall_cycles: got %0d expected 1", i, nStall); else passCount++;
      checkCount++; if (sa !== 1'b0) $display("[TB] FAIL err%0d_stall_at_ack: got %b expected 0", i, sa); else passCount++;
      checkCount++; if (dn !== lastDout2) $display("[TB] FAIL err%0d_dout_next: got %h expected %h", i, dn, lastDout2); else passCount++;
    end
  endtask

  task automatic test_both_enables();
    int lat, nStall; logic sa, e, sn; logic [31:0] d, dn;
    runReq2(1'b0, 1'b1, 32'h4, 32'h0BADF00D, lat, nStall, sa, e, d, dn, sn);
    mdl2[1] = 32'h0BADF00D;
    checkCount++; if (lat !== 3) $display("[TB] FAIL both_prewrite_latency: got %0d expected 3", lat); else passCount++;
    runReq2(1'b1, 1'b1, 32'h4, 32'hFFFFFFFF, lat, nStall, sa, e, d, dn, sn);
    checkCount++; if (lat !== 1) $display("[TB] FAIL both_latency: got %0d expected 1", lat); else passCount++;
    checkCount++; if (e !== 1'b1) $display("[TB] FAIL both_err: got %b expected 1", e); else passCount++;
    checkCount++; if (d !== lastDout2) $display("[TB] FAIL both_dout: got %h expected %h", d, lastDout2); else passCount++;
    runReq2(1'b1, 1'b0, 32'h4, 32'h0, lat, nStall, sa, e, d, dn, sn);
    checkCount++; if (d !== 32'h0BADF00D) $display("[TB] FAIL both_readback: got %h expected 0badf00d", d); else passCount++;
    lastDout2 = 32'h0BADF00D;
  endtask

  task automatic test_reset_abort();
    int lat, nStall; logic sa, e, sn; logic [31:0] d, dn;
    runReq2(1'b0, 1'b1, 32'h20, 32'hA5A50001, lat, nStall, sa, e, d, dn, sn);
    mdl2[8] = 32'hA5A50001;
    checkCount++; if (lat !== 3) $display("[TB] FAIL abort_prewrite_latency: got %0d expected 3", lat); else passCount++;
    @(posedge clk); #1;
    wen2 = 1'b1; addr2 = 32'h20; din2 = 32'h12345678;
    @(negedge clk);
    checkCount++; if (stall2 !== 1'b1) $display("[TB] FAIL abort_stall_T: got %b expected 1", stall2); else passCount++;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; wen2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkCount++; if (ack2 !== 1'b0) $display("[TB] FAIL abort_ack: got %b expected 0", ack2); else passCount++;
    checkCount++; if (stall2 !== 1'b0) $display("[TB] FAIL abort_stall: got %b expected 0", stall2); else passCount++;
    checkCount++; if (dout2 !== 32'd0) $display("[TB] FAIL abort_dout: got %h expected 0", dout2); else passCount++;
    lastDout2 = 32'd0;
    runReq2(1'b1, 1'b0, 32'h20, 32'h0, lat, nStall, sa, e, d, dn, sn);
    checkCount++; if (lat !== 3) $display("[TB] FAIL abort_read_latency: got %0d expected 3", lat); else passCount++;
    checkCount++; if (d !== 32'hA5A50001) $display("[TB] FAIL abort_readback: got %h expected a5a50001", d); else passCount++;
    lastDout2 = 32'hA5A50001;
  endtask

  task automatic test_random();
    int lat, nStall, expLat, r; logic sa, e, sn, rd, wr, expE; logic [31:0] d, dn, a, wd, expD;
    for (int i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(4 * i); wd = $urandom;
      runReq2(1'b0, 1'b1, a, wd, lat, nStall, sa, e, d, dn, sn);
      mdl2[int'(a[11:2])] = wd;
      checkCount++; if (lat !== 3) $display("[TB] FAIL rnd_init%0d_latency: got %0d expected 3", i, lat); else passCount++;
    end
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      wd = $urandom;
      rd = (r >= 4); wr = (r < 4);
      if (r == 8) a = a | 32'($urandom_range(1, 3));
      if (r == 9) a = a | (32'h1 << $urandom_range(12, 31));
      expE = isErr(rd, wr, a);
      expLat = expE ? 1 : 3;
      if (!expE && wr) mdl2[int'(a[11:2])] = wd;
      expD = (!expE && rd) ? mdl2[int'(a[11:2])] : lastDout2;
      runReq2(rd, wr, a, wd, lat, nStall, sa, e, d, dn, sn);
      checkCount++; if (lat !== expLat) $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", i, lat, expLat); else passCount++;
      checkCount++; if (e !== expE) $display("[TB] FAIL rnd%0d_err: got %b expected %b", i, e, expE); else passCount++;
      checkCount++; if (d !== expD) $display("[TB] FAIL rnd%0d_dout: got %h expected %h", i, d, expD); else passCount++;
      lastDout2 = expD;
    end
  endtask

  task automatic test_back_to_back_zero_wait();
    logic        opWr [6];
    logic [31:0] opAddr [6];
    logic [31:0] opData [6];
    int ackCyc, prevAck, lat;
    for (int k = 0; k < 6; k++) begin
      opWr[k] = (k % 2 == 0);
      opAddr[k] = 32'(4 * (k / 2));
      opData[k] = $urandom;
    end
    prevAck = -1;
    @(posedge clk); #1;
    ren0 = !opWr[0]; wen0 = opWr[0]; addr0 = opAddr[0]; din0 = opData[0];
    for (int k = 0; k < 6; k++) begin
      lat = -1; ackCyc = -1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (ack0 === 1'b1) begin lat = c; ackCyc = cyc; break; end
      end
      checkCount++; if (lat !== 1) $display("[TB] FAIL b2b%0d_latency: got %0d expected 1", k, lat); else passCount++;
      checkCount++; if (err0 !== 1'b0) $display("[TB] FAIL b2b%0d_err: got %b expected 0", k, err0); else passCount++;
      if (opWr[k]) begin
        mdl0[int'(opAddr[k][11:2])] = opData[k];
      end else begin
        checkCount++;
        if (dout0 !== mdl0[int'(opAddr[k][11:2])]) $display("[TB] FAIL b2b%0d_data: got %h expected %h", k, dout0, mdl0[int'(opAddr[k][11:2])]);
        else passCount++;
      end
      if (k > 0) begin
        checkCount++; if (ackCyc - prevAck !== 2) $display("[TB] FAIL b2b%0d_spacing: got %0d expected 2", k, ackCyc - prevAck); else passCount++;
      end
      prevAck = ackCyc;
      @(posedge clk); #1;
      if (k < 5) begin
        ren0 = !opWr[k+1]; wen0 = opWr[k+1]; addr0 = opAddr[k+1]; din0 = opData[k+1];
      end else begin
        ren0 = 1'b0; wen0 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_both_enables();
    test_reset_abort();
    test_random();
    test_back_to_back_zero_wait();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
